flex_fifo: RTL and testbench

Parametrised single-clock synchronous FIFO. It is the next-generation, portable replacement for the fixed 512-deep primitive FIFO wrapper.
- Adds configurable depth, exact occupancy count, programmable almost-full/almost-empty thresholds, selectable first-word-fall-through (FWFT) mode, and overflow/underflow error pulses.
- Sits between producer/consumer stages of the chip's peripheral and debug datapaths. Uses inferred RAM, so FPGA and ASIC builds share one RTL path.

---
 rtl/fifo_pkg.sv | 48 ++++
 rtl/fifo_ram.sv | 30 +++
 rtl/flex_fifo.sv | 124 ++++++++++++
 tb/tb_flex_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, prefetch state encoding and parameter checks
// for the flex_fifo family.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
    } pf_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit fifo_params_ok(
        input int width,
        input int depth,
        input int fwft,
        input int af_offset,
        input int ae_offset,
        input int cw
    );
        bit ok;
        ok = 1'b1;
        if (width < 1 || width > 256) ok = 1'b0;
        if (!is_pow2(depth) || depth < 4 || depth > 4096) ok = 1'b0;
        if (fwft != FIFO_STD && fwft != FIFO_FWFT) ok = 1'b0;
        if (af_offset < 1 || af_offset > depth - 1) ok = 1'b0;
        if (ae_offset < 1 || ae_offset > depth - 1) ok = 1'b0;
        if (cw != clog2(depth) + 1) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with a registered, enabled read port.
// No reset on the array so a technology macro can replace it.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 512,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/flex_fifo.sv
// Parametrised single-clock FIFO with exact count, threshold flags,
// error pulses and an optional first-word-fall-through prefetch stage.
module flex_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 36,
    parameter int DEPTH     = 512,
    parameter int FWFT      = 0,
    parameter int AF_OFFSET = 8,
    parameter int AE_OFFSET = 8,
    parameter int CW        = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             wr_err,
    output logic             rd_err
);

    localparam int AW = clog2(DEPTH);
    localparam bit IS_FWFT = (FWFT == FIFO_FWFT);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL  = CW'(DEPTH - AF_OFFSET);
    localparam logic [CW-1:0] AE_LVL  = CW'(AE_OFFSET);

    if (!fifo_params_ok(WIDTH, DEPTH, FWFT, AF_OFFSET, AE_OFFSET, CW)) begin : g_param_err
        $error("flex_fifo: illegal parameter set");
    end

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt_d;
    logic             empty_std;
    logic             shown;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_re;
    logic             out_valid;
    logic [WIDTH-1:0] ram_q;
    pf_state_e        state;

    assign empty  = IS_FWFT ? (state != VALID) : empty_std;
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;
    assign cnt_d  = count + CW'(wr_acc) - CW'(rd_acc);

    // In FWFT mode the RAM is read ahead of the consumer; while a word
    // sits in the prefetch stage, count exceeds the RAM occupancy by one.
    always_comb begin
        ram_re = 1'b0;
        if (IS_FWFT) begin
            unique case (state)
                IDLE:    ram_re = (count != '0);
                VALID:   ram_re = rd_acc && (count > CW'(1));
                default: ram_re = 1'b0;
            endcase
        end else begin
            ram_re = rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty_std    <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            wr_err       <= 1'b0;
            rd_err       <= 1'b0;
            shown        <= 1'b0;
            state        <= IDLE;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (ram_re) rptr <= rptr + 1'b1;
            count        <= cnt_d;
            full         <= (cnt_d == DEPTH_C);
            empty_std    <= (cnt_d == '0);
            almost_full  <= (cnt_d >= AF_LVL);
            almost_empty <= (cnt_d <= AE_LVL);
            wr_err       <= wr_en & full;
            rd_err       <= rd_en & empty;
            if (rd_acc) shown <= 1'b1;
            if (IS_FWFT) begin
                unique case (state)
                    IDLE:    if (ram_re) state <= FETCH;
                    FETCH:   state <= VALID;
                    VALID:   if (rd_acc && !ram_re) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The RAM array is never reset, so its output is masked until it
    // holds a word that was actually read out.
    assign out_valid = IS_FWFT ? (state == VALID) : shown;
    assign dout      = out_valid ? ram_q : '0;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (din),
        .re    (ram_re),
        .raddr (rptr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_flex_fifo.sv
// Bench for flex_fifo: a standard and an FWFT instance side by side,
// checked against queue-based reference models.
module tb_flex_fifo;

    localparam int W  = 36;
    localparam int D  = 16;
    localparam int CW = 5;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         wr_en;
    logic         rd_s;
    logic         rd_f;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_full, f_full;
    logic          s_empty, f_empty;
    logic          s_af, f_af;
    logic          s_ae, f_ae;
    logic [CW-1:0] s_count, f_count;
    logic          s_wr_err, f_wr_err;
    logic          s_rd_err, f_rd_err;

    int n_checks;
    int n_pass;

    logic [W-1:0] qs[$];
    logic [W-1:0] qf[$];
    logic [W-1:0] ms_dout;
    logic ms_werr, ms_rerr, mf_werr, mf_rerr;
    int stall;

    flex_fifo #(
        .WIDTH (W), .DEPTH (D), .FWFT (0), .AF_OFFSET (8), .AE_OFFSET (8)
    ) u_std (
        .clk (clk), .rst_n (rst_n), .din (din), .wr_en (wr_en),
        .rd_en (rd_s), .dout (s_dout), .full (s_full), .empty (s_empty),
        .almost_full (s_af), .almost_empty (s_ae), .count (s_count),
        .wr_err (s_wr_err), .rd_err (s_rd_err)
    );

    flex_fifo #(
        .WIDTH (W), .DEPTH (D), .FWFT (1), .AF_OFFSET (8), .AE_OFFSET (8)
    ) u_fwft (
        .clk (clk), .rst_n (rst_n), .din (din), .wr_en (wr_en),
        .rd_en (rd_f), .dout (f_dout), .full (f_full), .empty (f_empty),
        .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
        .wr_err (f_wr_err), .rd_err (f_rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_update(input logic pre_f_empty);
        if (!rst_n) begin
            qs.delete();
            qf.delete();
            ms_dout = '0;
            ms_werr = 1'b0;
            ms_rerr = 1'b0;
            mf_werr = 1'b0;
            mf_rerr = 1'b0;
        end else begin
            ms_werr = wr_en && (qs.size() == D);
            ms_rerr = rd_s && (qs.size() == 0);
            if (rd_s && qs.size() != 0) ms_dout = qs.pop_front();
            if (wr_en && !ms_werr) qs.push_back(din);
            mf_werr = wr_en && (qf.size() == D);
            mf_rerr = rd_f && pre_f_empty;
            if (rd_f && !pre_f_empty && qf.size() != 0) void'(qf.pop_front());
            if (wr_en && !mf_werr) qf.push_back(din);
        end
    endtask

    task automatic compare_all();
        check("s_count", 64'(s_count), 64'(qs.size()));
        check("s_full", 64'(s_full), 64'(qs.size() == D));
        check("s_empty", 64'(s_empty), 64'(qs.size() == 0));
        check("s_af", 64'(s_af), 64'(qs.size() >= D - 8));
        check("s_ae", 64'(s_ae), 64'(qs.size() <= 8));
        check("s_dout", 64'(s_dout), 64'(ms_dout));
        check("s_wr_err", 64'(s_wr_err), 64'(ms_werr));
        check("s_rd_err", 64'(s_rd_err), 64'(ms_rerr));
        check("f_count", 64'(f_count), 64'(qf.size()));
        check("f_full", 64'(f_full), 64'(qf.size() == D));
        check("f_af", 64'(f_af), 64'(qf.size() >= D - 8));
        check("f_ae", 64'(f_ae), 64'(qf.size() <= 8));
        check("f_wr_err", 64'(f_wr_err), 64'(mf_werr));
        check("f_rd_err", 64'(f_rd_err), 64'(mf_rerr));
        if (qf.size() == 0) begin
            check("f_empty_when_none", 64'(f_empty), 64'(1));
        end else if (!f_empty) begin
            check("f_dout_head", 64'(f_dout), 64'(qf[0]));
        end
        stall = (f_empty && qf.size() != 0) ? stall + 1 : 0;
        check("f_stall_bound", 64'(stall <= 2), 64'(1));
    endtask

    task automatic step();
        logic pe;
        pe = f_empty;
        @(posedge clk);
        #1;
        model_update(pe);
        compare_all();
    endtask

    task automatic drive(input logic w, input logic [W-1:0] d,
                         input logic rs, input logic rf);
        wr_en = w;
        din   = d;
        rd_s  = rs;
        rd_f  = rf;
        step();
    endtask

    initial begin
        int wr_pct;
        n_checks = 0;
        n_pass   = 0;
        stall    = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        din   = '0;
        rd_s  = 1'b0;
        rd_f  = 1'b0;

        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("rst_s_ae", 64'(s_ae), 64'(1));
        check("rst_f_empty", 64'(f_empty), 64'(1));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(1, W'(i), 0, 0);
            if (i == 7) check("af_at_8", 64'(s_af), 64'(1));
            if (i == 6) check("af_at_7", 64'(s_af), 64'(0));
        end
        check("fill_full", 64'(s_full), 64'(1));
        drive(1, W'(16), 0, 0);
        check("wr_err_17", 64'(s_wr_err), 64'(1));
        check("count_17", 64'(s_count), 64'(16));
        drive(0, 0, 0, 0);
        check("wr_err_one_cycle", 64'(s_wr_err), 64'(0));

        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 1);
            check("drain_dout", 64'(s_dout), 64'(i));
        end
        check("drain_empty", 64'(s_empty), 64'(1));
        drive(0, 0, 1, 1);
        check("rd_err_extra", 64'(s_rd_err), 64'(1));
        check("dout_holds", 64'(s_dout), 64'(15));

        drive(1, W'('h55), 1, 1);
        check("simul_empty_cnt", 64'(s_count), 64'(1));
        check("simul_empty_rerr", 64'(s_rd_err), 64'(1));
        for (int i = 0; i < 15; i++) drive(1, W'(32 + i), 0, 0);
        drive(0, 0, 0, 0);
        drive(1, W'('h77), 1, 1);
        check("simul_full_cnt", 64'(s_count), 64'(15));
        check("simul_full_werr", 64'(s_wr_err), 64'(1));
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

        drive(1, W'('hA5), 0, 0);
        check("fwft_lat0", 64'(f_empty), 64'(1));
        drive(0, 0, 0, 0);
        check("fwft_lat1", 64'(f_empty), 64'(1));
        drive(0, 0, 0, 0);
        check("fwft_lat2", 64'(f_empty), 64'(0));
        check("fwft_a5", 64'(f_dout), 64'('hA5));
        drive(1, W'(1), 0, 0);
        drive(1, W'(2), 0, 0);
        check("fwft_hold_a5", 64'(f_dout), 64'('hA5));
        drive(0, 0, 0, 1);
        check("fwft_seq1", 64'(f_dout), 64'(1));
        drive(0, 0, 0, 1);
        check("fwft_seq2", 64'(f_dout), 64'(2));
        drive(0, 0, 0, 1);
        check("fwft_seq_empty", 64'(f_empty), 64'(1));
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);

        for (int i = 0; i < 3; i++) drive(1, W'(200 + i), 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive(1, W'(300 + i), 1, 1);
            check("wrap_s_cnt", 64'(s_count), 64'(3));
            check("wrap_f_cnt", 64'(f_count), 64'(3));
        end
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        for (int i = 0; i < 9; i++) drive(1, W'(500 + i), 0, 0);
        check("pre_rst_cnt", 64'(s_count), 64'(9));
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        check("mid_rst_cnt", 64'(s_count), 64'(0));
        check("mid_rst_empty", 64'(s_empty), 64'(1));
        check("mid_rst_full", 64'(s_full), 64'(0));
        check("mid_rst_dout", 64'(s_dout), 64'(0));
        check("mid_rst_f_empty", 64'(f_empty), 64'(1));
        drive(0, 0, 1, 1);
        drive(1, W'(700), 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 1);
        check("post_rst_data", 64'(s_dout), 64'(700));

        wr_pct = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 150 == 0) wr_pct = (i / 150) % 3 == 0 ? 80 :
                                       (i / 150) % 3 == 1 ? 20 : 50;
            rst_n = ($urandom_range(0, 299) != 0);
            drive(($urandom_range(0, 99) < wr_pct), W'({$urandom, $urandom}),
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 50));
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
